// File: rtl/epu_sram_responder.sv
// Single-port EPU buffer bank: pipelined compute reads, byte-lane writes,
// and a host load/unload port that only uses cycles the compute side leaves free.
module epu_sram_responder #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cs,
  input  logic                oe,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] W_req,
  input  logic [DATA_W-1:0]   W_data,
  output logic [DATA_W-1:0]   R_data,
  input  logic                h_valid,
  output logic                h_ready,
  input  logic                h_we,
  input  logic [ADDR_W-1:0]   h_addr,
  input  logic [DATA_W-1:0]   h_wdata,
  output logic                h_rvalid,
  output logic [DATA_W-1:0]   h_rdata,
  output logic                err
);

  localparam int NB = DATA_W / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int P  = RD_LAT - 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              c_wr, c_rd, c_in;
  logic              h_acc, h_wr, h_rd, h_in;
  logic              bad;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_in;
  logic [DATA_W-1:0] rd_word;

  logic              c_fin, h_fin;
  logic [DATA_W-1:0] c_fd, h_fd;

  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic [DATA_W-1:0] h_rdata_q, h_rdata_d;
  logic              h_rvalid_q, h_rvalid_d;
  logic              err_q, err_d;

  assign c_wr  = cs & ~&W_req;
  assign c_rd  = cs & oe & &W_req;
  assign c_in  = {1'b0, addr} < DEPTH_C;
  assign h_acc = h_valid & ~cs;
  assign h_wr  = h_acc & h_we;
  assign h_rd  = h_acc & ~h_we;
  assign h_in  = {1'b0, h_addr} < DEPTH_C;
  assign bad   = ((c_wr | c_rd) & ~c_in) | (h_acc & ~h_in);

  // Only one port touches the array per cycle, so one read mux serves both.
  assign rd_addr = cs ? addr : h_addr;
  assign rd_in   = cs ? c_in : h_in;
  assign rd_word = rd_in ? mem_q[rd_addr[IW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (c_wr && c_in) begin
      for (int i = 0; i < NB; i++) begin
        if (!W_req[i]) begin
          mem_q[addr[IW-1:0]][8*i +: 8] <= W_data[8*i +: 8];
        end
      end
    end
    if (h_wr && h_in) begin
      mem_q[h_addr[IW-1:0]] <= h_wdata;
    end
  end

  generate
    if (P == 0) begin : g_lat1
      assign c_fin = c_rd;
      assign c_fd  = rd_word;
      assign h_fin = h_rd;
      assign h_fd  = rd_word;
    end else begin : g_latn
      logic [P-1:0]      cv_q, hv_q;
      logic [DATA_W-1:0] cd_q [P];
      logic [DATA_W-1:0] hd_q [P];

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          cv_q <= '0;
          hv_q <= '0;
          for (int k = 0; k < P; k++) begin
            cd_q[k] <= '0;
            hd_q[k] <= '0;
          end
        end else begin
          cv_q[0] <= c_rd;
          hv_q[0] <= h_rd;
          if (c_rd) cd_q[0] <= rd_word;
          if (h_rd) hd_q[0] <= rd_word;
          for (int k = 1; k < P; k++) begin
            cv_q[k] <= cv_q[k-1];
            hv_q[k] <= hv_q[k-1];
            if (cv_q[k-1]) cd_q[k] <= cd_q[k-1];
            if (hv_q[k-1]) hd_q[k] <= hd_q[k-1];
          end
        end
      end

      assign c_fin = cv_q[P-1];
      assign c_fd  = cd_q[P-1];
      assign h_fin = hv_q[P-1];
      assign h_fd  = hd_q[P-1];
    end
  endgenerate

  always_comb begin
    r_data_d   = r_data_q;
    h_rdata_d  = h_rdata_q;
    h_rvalid_d = h_fin;
    err_d      = err_q | bad;
    if (c_fin) r_data_d  = c_fd;
    if (h_fin) h_rdata_d = h_fd;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data_q   <= '0;
      h_rdata_q  <= '0;
      h_rvalid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      r_data_q   <= r_data_d;
      h_rdata_q  <= h_rdata_d;
      h_rvalid_q <= h_rvalid_d;
      err_q      <= err_d;
    end
  end

  assign h_ready  = ~cs;
  assign R_data   = r_data_q;
  assign h_rdata  = h_rdata_q;
  assign h_rvalid = h_rvalid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_epu_sram_responder.sv
// Bench for epu_sram_responder: three instances (RD_LAT 1..3) share stimulus,
// a reference memory model feeds a per-latency response scoreboard.
module tb_epu_sram_responder;

  localparam int DW    = 32;
  localparam int DEPTH = 4096;
  localparam int AW    = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cs, oe, h_valid, h_we;
  logic [AW-1:0] addr, h_addr;
  logic [3:0]    W_req;
  logic [DW-1:0] W_data, h_wdata;

  logic [DW-1:0] r_data  [3];
  logic [DW-1:0] h_rdata [3];
  logic          h_ready [3];
  logic          h_rvalid[3];
  logic          err     [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    epu_sram_responder #(
      .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .RD_LAT(g + 1)
    ) u_dut (
      .clk(clk), .rstn(rstn), .cs(cs), .oe(oe), .addr(addr),
      .W_req(W_req), .W_data(W_data), .R_data(r_data[g]),
      .h_valid(h_valid), .h_ready(h_ready[g]), .h_we(h_we),
      .h_addr(h_addr), .h_wdata(h_wdata), .h_rvalid(h_rvalid[g]),
      .h_rdata(h_rdata[g]), .err(err[g])
    );
  end

  typedef struct {
    logic          cs, oe;
    logic [AW-1:0] addr;
    logic [3:0]    wreq;
    logic [DW-1:0] wdata;
    logic          hv, hwe;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwdata;
    logic          exp_ready;
  } vec_t;

  typedef struct {
    int            lat;
    bit            host;
    int            due;
    logic [DW-1:0] val;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mm [DEPTH];
  logic [DW-1:0] exp_r[3], exp_h[3];
  logic          err_m;
  int            cyc, checks, fails;
  vec_t          tv[7];

  function automatic vec_t mk(logic c, logic o, logic [AW-1:0] a,
                              logic [3:0] wr, logic [DW-1:0] wd,
                              logic hv, logic hw, logic [AW-1:0] ha,
                              logic [DW-1:0] hd, logic rdy);
    vec_t v;
    v.cs = c; v.oe = o; v.addr = a; v.wreq = wr; v.wdata = wd;
    v.hv = hv; v.hwe = hw; v.haddr = ha; v.hwdata = hd;
    v.exp_ready = rdy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    cs = v.cs; oe = v.oe; addr = v.addr; W_req = v.wreq;
    W_data = v.wdata; h_valid = v.hv; h_we = v.hwe;
    h_addr = v.haddr; h_wdata = v.hwdata;
  endtask

  task automatic idle_in();
    drive(mk(0, 0, 0, 4'hF, 0, 0, 0, 0, 0, 1));
  endtask

  task automatic c_write(input logic [AW-1:0] a, input logic [3:0] wr,
                         input logic [DW-1:0] d);
    drive(mk(1, 0, a, wr, d, 0, 0, 0, 0, 0));
  endtask

  task automatic c_read(input logic [AW-1:0] a);
    drive(mk(1, 1, a, 4'hF, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic h_req(input logic hw, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    drive(mk(0, 0, 0, 4'hF, 0, 1, hw, a, d, 1));
  endtask

  task automatic check_ready(input logic exp);
    #1;
    for (int l = 0; l < 3; l++) chk("h_ready", 32'(h_ready[l]), 32'(exp));
  endtask

  task automatic push_rd(input bit host, input logic [DW-1:0] v);
    for (int l = 1; l <= 3; l++) begin
      exp_t e;
      e.lat = l; e.host = host; e.due = cyc + l; e.val = v;
      sb.push_back(e);
    end
  endtask

  task automatic check_outs();
    for (int l = 0; l < 3; l++) begin
      logic hv_e;
      hv_e = 1'b0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].lat == l + 1 && sb[i].due == cyc) begin
          if (sb[i].host) begin
            hv_e = 1'b1;
            exp_h[l] = sb[i].val;
          end else begin
            exp_r[l] = sb[i].val;
          end
          sb.delete(i);
        end
      end
      chk($sformatf("R_data lat%0d", l + 1), r_data[l], exp_r[l]);
      chk($sformatf("h_rvalid lat%0d", l + 1), 32'(h_rvalid[l]), 32'(hv_e));
      chk($sformatf("h_rdata lat%0d", l + 1), h_rdata[l], exp_h[l]);
      chk($sformatf("err lat%0d", l + 1), 32'(err[l]), 32'(err_m));
    end
  endtask

  // Model the edge using the inputs currently driven, then clock and check.
  task automatic step();
    logic c_in, h_in;
    c_in = addr < AW'(DEPTH);
    h_in = h_addr < AW'(DEPTH);
    if (cs && W_req != 4'hF) begin
      if (c_in) begin
        for (int i = 0; i < 4; i++)
          if (!W_req[i]) mm[addr][8*i +: 8] = W_data[8*i +: 8];
      end else err_m = 1'b1;
    end else if (cs && oe) begin
      push_rd(1'b0, c_in ? mm[addr] : '0);
      if (!c_in) err_m = 1'b1;
    end
    if (h_valid && !cs) begin
      if (!h_in) err_m = 1'b1;
      if (h_we) begin
        if (h_in) mm[h_addr] = h_wdata;
      end else begin
        push_rd(1'b1, h_in ? mm[h_addr] : '0);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outs();
  endtask

  task automatic model_reset();
    sb.delete();
    for (int l = 0; l < 3; l++) begin
      exp_r[l] = '0;
      exp_h[l] = '0;
    end
    err_m = 1'b0;
  endtask

  task automatic hand_r(input string nm, input logic [DW-1:0] v);
    for (int l = 0; l < 3; l++) chk(nm, r_data[l], v);
  endtask

  initial begin
    checks = 0; fails = 0; cyc = 0;
    idle_in();
    model_reset();
    rstn = 1'b1;
    #2 rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_outs();
    @(negedge clk);
    rstn = 1'b1;

    tv[0] = mk(1, 1, 5, 4'b0000, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    tv[1] = mk(1, 0, 5, 4'b1110, 32'h000000AA, 1, 0, 3, 0, 0);
    tv[2] = mk(1, 1, 5, 4'b1111, 0, 0, 0, 0, 0, 0);
    tv[3] = mk(0, 0, 0, 4'b1111, 0, 0, 0, 0, 0, 1);
    tv[4] = mk(1, 0, 9, 4'b1111, 0, 0, 0, 0, 0, 0);
    tv[5] = mk(0, 1, 7, 4'b1111, 0, 0, 0, 0, 0, 1);
    tv[6] = mk(0, 0, 0, 4'b1111, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      drive(tv[i]);
      check_ready(tv[i].exp_ready);
      step();
    end
    hand_r("lane write", 32'hDEADBEAA);

    for (int a = 0; a < 8; a++) begin
      c_write(AW'(a), 4'h0, DW'(a * 3));
      step();
    end
    for (int a = 0; a < 8; a++) begin
      c_read(AW'(a));
      step();
    end
    for (int i = 0; i < 4; i++) begin
      idle_in();
      step();
    end
    hand_r("pipelined tail", 32'd21);

    for (int i = 1; i <= 4; i++) begin
      drive(mk(1, 1, AW'(i), 4'hF, 0, 1, 1, 10, 32'h1234, 0));
      check_ready(1'b0);
      step();
    end
    h_req(1'b1, 10, 32'h1234);
    check_ready(1'b1);
    step();
    c_read(10);
    step();
    for (int i = 0; i < 3; i++) begin
      idle_in();
      step();
    end
    hand_r("host stall write", 32'h1234);

    drive(mk(1, 1, 0, 4'hF, 0, 1, 0, 3, 0, 0));
    step();
    h_req(1'b0, 3, 0);
    step();
    c_read(1);
    step();
    c_read(2);
    step();
    c_read(6);
    step();
    for (int i = 0; i < 4; i++) begin
      idle_in();
      step();
    end
    for (int l = 0; l < 3; l++) chk("host rdata hold", h_rdata[l], 32'd9);
    hand_r("interleaved tail", 32'd18);

    h_req(1'b1, AW'(DEPTH - 1), 32'hCAFEF00D);
    step();
    c_read(AW'(DEPTH - 1));
    step();
    c_read(AW'(DEPTH));
    step();
    for (int i = 0; i < 3; i++) begin
      idle_in();
      step();
    end
    hand_r("oor read", 32'h0);
    for (int l = 0; l < 3; l++) chk("err set", 32'(err[l]), 32'd1);
    c_read(5);
    step();
    c_write(AW'(DEPTH + 5), 4'h0, 32'h55555555);
    step();
    c_read(5);
    step();
    h_req(1'b0, 16'hFFFF, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      idle_in();
      step();
    end
    hand_r("oor write dropped", 32'd15);

    h_req(1'b0, 5, 0);
    step();
    idle_in();
    rstn = 1'b0;
    model_reset();
    #1;
    check_outs();
    @(posedge clk);
    @(negedge clk);
    check_outs();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) step();
    for (int l = 0; l < 3; l++) chk("err cleared", 32'(err[l]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/epu_sram_responder.md
Name: epu_sram_responder

Overview:
- Memory-side responder for the EPU's single-port RAM interface: cs, oe, addr, W_req, W_data, R_data.
- Sits behind the convolution bus switcher, one instance per buffer (param, bias, weight, input, output).
- Serves the compute path with a fixed, pipelined read latency and byte-lane writes.
- Adds a host load/unload port with a valid/ready handshake; the host uses the bank only in cycles the compute side leaves free.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 4096, number of words in the bank.
- ADDR_W, 16, address width of both ports; DEPTH <= 2**ADDR_W.
- RD_LAT, 1, read latency in cycles; legal values 1..3.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- cs  in  1  compute chip select.
- oe  in  1  compute output enable (read request when cs=1 and no write).
- addr  in  ADDR_W  compute word address.
- W_req  in  DATA_W/8  per-byte write request, active-low; all-ones = write disabled.
- W_data  in  DATA_W  compute write data.
- R_data  out  DATA_W  compute read data.
- h_valid  in  1  host request valid.
- h_ready  out  1  host request accepted.
- h_we  in  1  host write (1) / read (0).
- h_addr  in  ADDR_W  host word address.
- h_wdata  in  DATA_W  host write data (full word).
- h_rvalid  out  1  host read data valid, one-cycle pulse.
- h_rdata  out  DATA_W  host read data.
- err  out  1  sticky out-of-range access flag.

Behaviour:
- Reset (rstn=0, async): R_data=0, h_rdata=0, h_rvalid=0, err=0, all read-pipeline valid bits cleared. Array contents are not reset.
- Compute write: cs=1 and any W_req bit 0 → write byte lane i of W_data at addr for every W_req[i]=0, at the clock edge. oe is ignored. No R_data update is issued.
- Compute read: cs=1, oe=1, W_req all-ones → array word at addr appears on R_data exactly RD_LAT edges later. Back-to-back reads are fully pipelined, one per cycle.
- Idle compute cycles (cs=0, or cs=1 with oe=0 and no write): R_data holds its last value.
- Read after write: a write at edge N followed by a read of the same address issued at edge N+1 returns the new data. A single port never sees both in the same cycle.
- Host arbitration: h_ready = ~cs, combinational. The compute side is never stalled. A host transfer completes on an edge with h_valid & h_ready. While h_valid=1 and h_ready=0, the host holds h_we, h_addr and h_wdata stable.
- Host write: full-word write to h_addr at the accept edge.
- Host read: h_rdata valid with h_rvalid=1 exactly RD_LAT edges after accept. h_rdata holds until the next host read response. Host and compute read pipelines are tagged separately, so responses never cross between ports.
- Out of range (addr >= DEPTH on an active access, either port):
  - write is dropped;
  - read returns 0 with normal latency and valid;
  - err is set and stays 1 until reset.
- Reset mid-operation: in-flight read responses are discarded and h_rvalid stays 0 after reset release until a new accepted read.
- No combinational path from cs/addr to R_data. The h_ready path from cs is the only combinational path.

Test Plan:
- Reset values, then compute writes:
  - Sequence: write 0xDEADBEEF @5 with W_req=4'b0000; write 0x000000AA @5 with W_req=4'b1110; read @5.
  - Required: R_data=0xDEADBEAA exactly RD_LAT cycles after the read. Reset values are checked first.
- Pipelined reads:
  - Sequence: compute reads @0..7 on consecutive cycles after preloading value = addr*3.
  - Required: R_data = 0,3,...,21 on consecutive cycles, starting RD_LAT after the first read. Repeat for RD_LAT=1 and RD_LAT=3.
- Host stall:
  - Sequence: h_valid=1, write 0x1234 @10 while cs=1 for 4 cycles; then cs=0.
  - Required: h_ready=0 for 4 cycles, accept on the 5th edge; a compute read @10 afterwards returns 0x1234.
- Host read with interleaved compute reads:
  - Required: h_rvalid pulses once with correct data; R_data stream is unaffected.
- Out-of-range read:
  - Sequence: compute read @DEPTH.
  - Required: R_data=0 after RD_LAT cycles, err=1, err persists through later valid accesses and clears only on rstn=0.
- Reset mid-read:
  - Sequence: assert rstn=0 one cycle after a host read accept with RD_LAT=2.
  - Required: h_rvalid never pulses for that read; R_data=0.
